// File: rtl/semaphore_pkg.sv
// rtl/semaphore_pkg.sv - shared state encodings, lamp decode and tick defaults for the traffic-light head
//
// Contents:
//   state_t       4-bit state encoding (OFF, RED, YELLOW_RED, GREEN, YELLOW)
//   TIMER_W       width of the dwell down-counter
//   DEF_*_TICKS   default phase lengths in clock cycles
//   lamp_decode   state -> {red, yellow, green}

package semaphore_pkg;

    localparam int TIMER_W = 8;

    localparam int unsigned DEF_RED_TICKS        = 10;
    localparam int unsigned DEF_YELLOW_RED_TICKS = 2;
    localparam int unsigned DEF_GREEN_TICKS      = 8;
    localparam int unsigned DEF_YELLOW_TICKS     = 3;

    // Encodings are visible to the intersection controller through state_out,
    // so they are fixed values rather than tool-chosen.
    typedef enum logic [3:0] {
        ST_OFF        = 4'b0001,
        ST_RED        = 4'b0010,
        ST_YELLOW_RED = 4'b0011,
        ST_GREEN      = 4'b0100,
        ST_YELLOW     = 4'b0101
    } state_t;

    // Lamp vector ordering is {red, yellow, green}. Illegal encodings stay dark.
    function automatic logic [2:0] lamp_decode(input state_t s);
        logic [2:0] lamps;
        lamps = 3'b000;
        case (s)
            ST_OFF:        lamps = 3'b000;
            ST_RED:        lamps = 3'b100;
            ST_YELLOW_RED: lamps = 3'b110;
            ST_GREEN:      lamps = 3'b001;
            ST_YELLOW:     lamps = 3'b010;
            default:       lamps = 3'b000;
        endcase
        return lamps;
    endfunction

    // Converts a phase length (1..255) into the value loaded on phase entry.
    // The phase ends on the edge that sees the counter at zero, hence the -1.
    function automatic logic [TIMER_W-1:0] ticks_to_load(input int unsigned ticks);
        return TIMER_W'(ticks - 1);
    endfunction

endpackage

// File: rtl/semaphore_dwell_timer.sv
// rtl/semaphore_dwell_timer.sv - 8-bit phase dwell down-counter with load strobe and zero flag
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high; clears the counter
//   load      load strobe, asserted on the edge that enters a new state
//   load_val  value loaded when load is high
//   zero      high while the counter is 0 (current phase is in its last cycle)

module semaphore_dwell_timer
    import semaphore_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            // Saturates at zero so a head parked in OFF never wraps.
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/semaphore_ctrl_fsm.sv
// rtl/semaphore_ctrl_fsm.sv - Moore FSM for one traffic-light head, European RED/YELLOW_RED/GREEN/YELLOW sequence
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous reset, active-high (asserted = 1) despite the name
//   enable     1 = cycle the lights, 0 = go dark (sampled synchronously)
//   red        red lamp
//   yellow     yellow lamp
//   green      green lamp
//   state_out  current state register, no added latency

module semaphore_ctrl_fsm
    import semaphore_pkg::*;
#(
    parameter int unsigned RED_TICKS        = DEF_RED_TICKS,
    parameter int unsigned YELLOW_RED_TICKS = DEF_YELLOW_RED_TICKS,
    parameter int unsigned GREEN_TICKS      = DEF_GREEN_TICKS,
    parameter int unsigned YELLOW_TICKS     = DEF_YELLOW_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic [3:0] state_out
);

    localparam logic [TIMER_W-1:0] RED_LOAD        = ticks_to_load(RED_TICKS);
    localparam logic [TIMER_W-1:0] YELLOW_RED_LOAD = ticks_to_load(YELLOW_RED_TICKS);
    localparam logic [TIMER_W-1:0] GREEN_LOAD      = ticks_to_load(GREEN_TICKS);
    localparam logic [TIMER_W-1:0] YELLOW_LOAD     = ticks_to_load(YELLOW_TICKS);

    state_t             state_q;
    state_t             state_d;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               timer_zero;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_load     = 1'b0;
        timer_load_val = '0;

        if (!enable) begin
            // Going dark wins over everything, even mid-phase.
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:        state_d = ST_RED;
                ST_RED:        if (timer_zero) state_d = ST_YELLOW_RED;
                ST_YELLOW_RED: if (timer_zero) state_d = ST_GREEN;
                ST_GREEN:      if (timer_zero) state_d = ST_YELLOW;
                ST_YELLOW:     if (timer_zero) state_d = ST_RED;
                default:       state_d = ST_OFF;
            endcase
        end

        // Every state change is a phase entry and reloads the dwell timer.
        // Entering OFF loads 0, which discards whatever was left of the
        // abandoned phase. YELLOW->RED always changes state, so RED is
        // reloaded at the start of each lap.
        timer_load = (state_d != state_q);
        case (state_d)
            ST_RED:        timer_load_val = RED_LOAD;
            ST_YELLOW_RED: timer_load_val = YELLOW_RED_LOAD;
            ST_GREEN:      timer_load_val = GREEN_LOAD;
            ST_YELLOW:     timer_load_val = YELLOW_LOAD;
            default:       timer_load_val = '0;
        endcase
    end

    semaphore_dwell_timer u_dwell_timer (
        .clk      (clk),
        .rst      (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    assign state_out              = state_q;
    assign {red, yellow, green}   = lamp_decode(state_q);

endmodule

// File: tb/tb_semaphore_ctrl_fsm.sv
// tb/tb_semaphore_ctrl_fsm.sv - directed self-checking bench for semaphore_ctrl_fsm

module tb_semaphore_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       red, yellow, green;
    logic [3:0] state_out;

    logic       en2;
    logic       red2, yellow2, green2;
    logic [3:0] state2;

    int checks;
    int errors;

    localparam logic [3:0] S_OFF = 4'b0001;
    localparam logic [3:0] S_RED = 4'b0010;
    localparam logic [3:0] S_YR  = 4'b0011;
    localparam logic [3:0] S_GRN = 4'b0100;
    localparam logic [3:0] S_YEL = 4'b0101;

    logic [3:0] ph_state [4] = '{4'b0010, 4'b0011, 4'b0100, 4'b0101};
    logic [2:0] ph_lamp  [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
    int         ph_ticks [4] = '{10, 2, 8, 3};
    int         sh_ticks [4] = '{1, 2, 8, 1};

    semaphore_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .state_out (state_out)
    );

    semaphore_ctrl_fsm #(
        .RED_TICKS    (1),
        .YELLOW_TICKS (1)
    ) dut_short (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en2),
        .red       (red2),
        .yellow    (yellow2),
        .green     (green2),
        .state_out (state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        en2    = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
            errors++;
            $display("FAIL reset_immediate: state=%b lamps=%b expected state=%b lamps=000",
                     state_out, {red, yellow, green}, S_OFF);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: state=%b lamps=%b expected state=%b lamps=000",
                         i, state_out, {red, yellow, green}, S_OFF);
            end
        end
        #7 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: state=%b lamps=%b expected state=%b lamps=000",
                     state_out, {red, yellow, green}, S_OFF);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
                errors++;
                $display("FAIL idle[%0d]: state=%b lamps=%b expected state=%b lamps=000",
                         i, state_out, {red, yellow, green}, S_OFF);
            end
        end
    endtask

    task automatic test_full_cycle();
        enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                for (int k = 0; k < ph_ticks[p]; k++) begin
                    @(negedge clk);
                    checks++;
                    if (state_out !== ph_state[p] || {red, yellow, green} !== ph_lamp[p]) begin
                        errors++;
                        $display("FAIL full_cycle c%0d p%0d k%0d: state=%b lamps=%b expected state=%b lamps=%b",
                                 c, p, k, state_out, {red, yellow, green}, ph_state[p], ph_lamp[p]);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if (state_out !== S_RED || {red, yellow, green} !== 3'b100) begin
            errors++;
            $display("FAIL full_cycle_wrap: state=%b lamps=%b expected state=%b lamps=100",
                     state_out, {red, yellow, green}, S_RED);
        end
    endtask

    task automatic test_drop_yellow_red();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (state_out === S_YR) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL drop_wait_yr: state=%b expected to reach %b within 30 cycles", state_out, S_YR);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
                errors++;
                $display("FAIL drop_off[%0d]: state=%b lamps=%b expected state=%b lamps=000",
                         i, state_out, {red, yellow, green}, S_OFF);
            end
        end
    endtask

    task automatic test_reenable();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (state_out !== S_RED || {red, yellow, green} !== 3'b100) begin
                errors++;
                $display("FAIL reenable_red[%0d]: state=%b lamps=%b expected state=%b lamps=100",
                         i, state_out, {red, yellow, green}, S_RED);
            end
        end
        @(negedge clk);
        checks++;
        if (state_out !== S_YR || {red, yellow, green} !== 3'b110) begin
            errors++;
            $display("FAIL reenable_yr: state=%b lamps=%b expected state=%b lamps=110",
                     state_out, {red, yellow, green}, S_YR);
        end
    endtask

    task automatic test_back_to_back();
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
            errors++;
            $display("FAIL toggle_off: state=%b lamps=%b expected state=%b lamps=000",
                     state_out, {red, yellow, green}, S_OFF);
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (state_out !== S_RED || {red, yellow, green} !== 3'b100) begin
                errors++;
                $display("FAIL toggle_red[%0d]: state=%b lamps=%b expected state=%b lamps=100",
                         i, state_out, {red, yellow, green}, S_RED);
            end
        end
        @(negedge clk);
        checks++;
        if (state_out !== S_YR) begin
            errors++;
            $display("FAIL toggle_yr: state=%b expected %b", state_out, S_YR);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (state_out === S_GRN) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL async_wait_green: state=%b expected to reach %b within 30 cycles", state_out, S_GRN);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (state_out !== S_OFF || {red, yellow, green} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_mid_green: state=%b lamps=%b expected state=%b lamps=000",
                     state_out, {red, yellow, green}, S_OFF);
        end
        @(negedge clk);
        checks++;
        if (state_out !== S_OFF) begin
            errors++;
            $display("FAIL async_reset_held: state=%b expected %b", state_out, S_OFF);
        end
        enable = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== S_OFF) begin
            errors++;
            $display("FAIL async_reset_release: state=%b expected %b", state_out, S_OFF);
        end
    endtask

    task automatic test_short_params();
        checks++;
        if (state2 !== S_OFF || {red2, yellow2, green2} !== 3'b000) begin
            errors++;
            $display("FAIL short_idle: state=%b lamps=%b expected state=%b lamps=000",
                     state2, {red2, yellow2, green2}, S_OFF);
        end
        en2 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                for (int k = 0; k < sh_ticks[p]; k++) begin
                    @(negedge clk);
                    checks++;
                    if (state2 !== ph_state[p] || {red2, yellow2, green2} !== ph_lamp[p]) begin
                        errors++;
                        $display("FAIL short_cycle c%0d p%0d k%0d: state=%b lamps=%b expected state=%b lamps=%b",
                                 c, p, k, state2, {red2, yellow2, green2}, ph_state[p], ph_lamp[p]);
                    end
                end
            end
        end
        @(negedge clk);
        checks++;
        if (state2 !== S_RED) begin
            errors++;
            $display("FAIL short_wrap: state=%b expected %b", state2, S_RED);
        end
        @(negedge clk);
        checks++;
        if (state2 !== S_YR) begin
            errors++;
            $display("FAIL short_red_one_cycle: state=%b expected %b", state2, S_YR);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_full_cycle();
        test_drop_yellow_red();
        test_reenable();
        test_back_to_back();
        test_async_reset();
        test_short_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
